// File: rtl/rm14_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rm14_pkg
// Description : Shared definitions for the RM(1,4) decode controller: H-matrix
//               column masks, coset-leader table depth, status encoding, FSM
//               state encoding and the syndrome helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rm14_pkg;

    // All weight-1..3 error patterns plus one trailing pad entry
    localparam int c_TABLE_DEPTH = 697;
    localparam int c_SYN_W       = 11;

    // Column j of H: the syndrome bits that received bit rj (word bit 15-j) feeds
    localparam logic [10:0] c_H_COL [16] = '{
        11'b10000111111,   // r0
        11'b10111000111,   // r1
        11'b11011011001,   // r2
        11'b11101101010,   // r3
        11'b11110110100,   // r4
        11'b00000000001,   // r5
        11'b00000000010,   // r6
        11'b00000000100,   // r7
        11'b00000001000,   // r8
        11'b00000010000,   // r9
        11'b00000100000,   // r10
        11'b00001000000,   // r11
        11'b00010000000,   // r12
        11'b00100000000,   // r13
        11'b01000000000,   // r14
        11'b10000000000    // r15
    };

    typedef enum logic [1:0] {
        STATUS_CLEAN  = 2'b00,
        STATUS_CORR   = 2'b01,
        STATUS_UNCORR = 2'b10
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SYND   = 2'd1,
        S_SEARCH = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    // s = word * H^T, accumulated column by column
    function automatic logic [10:0] rm14_syndrome(input logic [15:0] word);
        logic [10:0] s;
        s = '0;
        for (int j = 0; j < 16; j++) begin
            if (word[4'(15 - j)]) begin
                s = s ^ c_H_COL[j[3:0]];
            end
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rm14_syndrome_rom.sv
`default_nettype none
// ============================================================================
// Module      : rm14_syndrome_rom
// Description : Coset-leader table. Entries are all error patterns of weight
//               1, 2 then 3, each weight in ascending rj-index order (r0 first).
//               Synchronous one-cycle read of pattern and its syndrome.
// Revision    : 1.0 - initial release
// ============================================================================
module rm14_syndrome_rom
    import rm14_pkg::*;
#(
    parameter int TABLE_DEPTH = c_TABLE_DEPTH,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    output logic [10:0]       rd_syn,
    output logic [15:0]       rd_pat
);

    logic [15:0] w_pat [TABLE_DEPTH];
    logic [15:0] r_pat;
    logic [10:0] r_syn;

    // Weight-1 patterns occupy entries 0..15
    for (genvar a = 0; a < 16; a++) begin : g_w1
        if (a < TABLE_DEPTH) begin : g_en
            assign w_pat[a] = 16'h8000 >> a;
        end
    end

    // Weight-2 patterns (ra, rb), a < b, occupy entries 16..135
    for (genvar a = 0; a < 15; a++) begin : g_w2a
        for (genvar b = a + 1; b < 16; b++) begin : g_w2b
            localparam int c_IDX = 16 + (120 - ((16 - a) * (15 - a)) / 2) + (b - a - 1);
            if (c_IDX < TABLE_DEPTH) begin : g_en
                assign w_pat[c_IDX] = (16'h8000 >> a) | (16'h8000 >> b);
            end
        end
    end

    // Weight-3 patterns (ra, rb, rc), a < b < c, occupy entries 136..695
    for (genvar a = 0; a < 14; a++) begin : g_w3a
        for (genvar b = a + 1; b < 15; b++) begin : g_w3b
            for (genvar c = b + 1; c < 16; c++) begin : g_w3c
                localparam int c_IDX = 136
                                     + (560 - ((16 - a) * (15 - a) * (14 - a)) / 6)
                                     + (((15 - a) * (14 - a)) / 2 - ((16 - b) * (15 - b)) / 2)
                                     + (c - b - 1);
                if (c_IDX < TABLE_DEPTH) begin : g_en
                    assign w_pat[c_IDX] = (16'h8000 >> a) | (16'h8000 >> b) | (16'h8000 >> c);
                end
            end
        end
    end

    // Pad entries carry a zero syndrome, which never matches a live search
    for (genvar p = 696; p < TABLE_DEPTH; p++) begin : g_pad
        assign w_pat[p] = 16'h0000;
    end

    // Registered table read; out-of-range addresses read as an empty entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat <= '0;
            r_syn <= '0;
        end else if (int'(addr) < TABLE_DEPTH) begin
            r_pat <= w_pat[addr];
            r_syn <= rm14_syndrome(w_pat[addr]);
        end else begin
            r_pat <= '0;
            r_syn <= '0;
        end
    end

    assign rd_pat = r_pat;
    assign rd_syn = r_syn;

endmodule
`default_nettype wire

// File: rtl/rm14_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rm14_decode_ctrl
// Description : RM(1,4) syndrome decoder controller. Computes the syndrome of
//               an accepted word, then scans the coset-leader table one entry
//               per cycle, first match wins. Reports message, applied error
//               pattern, status and saturating event counts.
// Revision    : 1.0 - initial release
// ============================================================================
module rm14_decode_ctrl
    import rm14_pkg::*;
#(
    parameter int TABLE_DEPTH = c_TABLE_DEPTH,
    parameter int ADDR_W      = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_msg,
    output logic [15:0] out_err,
    output logic [1:0]  out_status,
    output logic [15:0] corr_cnt,
    output logic [15:0] uncorr_cnt
);

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(TABLE_DEPTH - 1);

    state_e            r_state;
    logic [15:0]       r_word;
    logic [10:0]       r_syn;
    logic              r_syn_vld;   // syndrome register holds this word's value
    logic [ADDR_W-1:0] r_addr;
    logic              r_issuing;   // addresses still being issued
    logic              r_dvld;      // ROM data belongs to this search
    logic              r_dlast;     // ROM data is the final table entry
    logic              r_exh;       // final entry compared without a match
    logic              r_in_ready;
    logic              r_out_valid;
    logic [4:0]        r_msg;
    logic [15:0]       r_err;
    status_e           r_status;
    logic [15:0]       r_corr_cnt;
    logic [15:0]       r_uncorr_cnt;

    logic [10:0]       w_rom_syn;
    logic [15:0]       w_rom_pat;
    logic [15:0]       w_fixed;

    rm14_syndrome_rom #(
        .TABLE_DEPTH (TABLE_DEPTH),
        .ADDR_W      (ADDR_W)
    ) u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (r_addr),
        .rd_syn (w_rom_syn),
        .rd_pat (w_rom_pat)
    );

    assign w_fixed = r_word ^ w_rom_pat;

    // Decode sequencer: accept, syndrome, table scan, result hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_word       <= '0;
            r_syn        <= '0;
            r_syn_vld    <= 1'b0;
            r_addr       <= '0;
            r_issuing    <= 1'b0;
            r_dvld       <= 1'b0;
            r_dlast      <= 1'b0;
            r_exh        <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_msg        <= '0;
            r_err        <= '0;
            r_status     <= STATUS_CLEAN;
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_word     <= in_word;
                        r_syn_vld  <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_SYND;
                    end
                end

                S_SYND: begin
                    if (!r_syn_vld) begin
                        r_syn     <= rm14_syndrome(r_word);
                        r_syn_vld <= 1'b1;
                    end else begin
                        r_syn_vld <= 1'b0;
                        if (r_syn == '0) begin
                            r_msg       <= r_word[15:11];
                            r_err       <= '0;
                            r_status    <= STATUS_CLEAN;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_addr    <= '0;
                            r_issuing <= 1'b1;
                            r_dvld    <= 1'b0;
                            r_dlast   <= 1'b0;
                            r_exh     <= 1'b0;
                            r_state   <= S_SEARCH;
                        end
                    end
                end

                S_SEARCH: begin
                    // Issue stage: one address per cycle, holding at the last entry
                    r_dvld  <= r_issuing;
                    r_dlast <= r_issuing && (r_addr == c_LAST);
                    if (r_issuing) begin
                        if (r_addr == c_LAST) begin
                            r_issuing <= 1'b0;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                    // Compare stage: data of the entry issued last cycle
                    if (r_exh) begin
                        r_msg       <= r_word[15:11];
                        r_err       <= '0;
                        r_status    <= STATUS_UNCORR;
                        r_out_valid <= 1'b1;
                        r_issuing   <= 1'b0;
                        r_dvld      <= 1'b0;
                        r_exh       <= 1'b0;
                        r_state     <= S_DONE;
                        if (r_uncorr_cnt != 16'hFFFF) begin
                            r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
                        end
                    end else if (r_dvld && (w_rom_syn == r_syn)) begin
                        r_msg       <= w_fixed[15:11];
                        r_err       <= w_rom_pat;
                        r_status    <= STATUS_CORR;
                        r_out_valid <= 1'b1;
                        r_issuing   <= 1'b0;
                        r_dvld      <= 1'b0;
                        r_state     <= S_DONE;
                        if (r_corr_cnt != 16'hFFFF) begin
                            r_corr_cnt <= r_corr_cnt + 1'b1;
                        end
                    end else if (r_dvld && r_dlast) begin
                        r_exh <= 1'b1;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_msg    = r_msg;
    assign out_err    = r_err;
    assign out_status = r_status;
    assign corr_cnt   = r_corr_cnt;
    assign uncorr_cnt = r_uncorr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rm14_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rm14_decode_ctrl
// Description : Self-checking bench for rm14_decode_ctrl. Reference model
//               derives syndromes from the parity equations and enumerates
//               coset leaders by weight, then by descending word value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rm14_decode_ctrl;

    localparam int DEPTH = 697;
    // Parity-check rows s0..s10 as masks over the 16-bit word (r0 = bit 15)
    localparam logic [15:0] ROWS [11] = '{
        16'hE400, 16'hD200, 16'hC900, 16'hB080, 16'hA840, 16'h9820,
        16'h7010, 16'h6808, 16'h5804, 16'h3802, 16'hF801
    };

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic [15:0] in_word   = 16'h0000;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [4:0]  out_msg;
    logic [15:0] out_err;
    logic [1:0]  out_status;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;

    int          n_checks   = 0;
    int          n_fail     = 0;
    int          exp_corr   = 0;
    int          exp_uncorr = 0;
    logic [15:0] tbl [$];
    logic [10:0] tbl_syn [$];

    rm14_decode_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_msg    (out_msg),
        .out_err    (out_err),
        .out_status (out_status),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    function automatic logic [10:0] ref_syn(input logic [15:0] w);
        logic [10:0] s;
        s = '0;
        for (int i = 0; i < 11; i++) s[i[3:0]] = ^(w & ROWS[i[3:0]]);
        return s;
    endfunction

    function automatic logic [15:0] encode(input logic [4:0] m);
        logic [15:0] c;
        c = {m, 11'b0};
        for (int i = 0; i < 11; i++) begin
            if (^(c & ROWS[i[3:0]])) c[4'(10 - i)] = 1'b1;
        end
        return c;
    endfunction

    task automatic ref_decode(input logic [15:0] w, output int lat, output logic [4:0] msg,
                              output logic [15:0] err, output logic [1:0] st);
        logic [10:0] s;
        logic [15:0] fixed;
        s   = ref_syn(w);
        err = 16'h0000;
        if (s == 11'd0) begin
            lat = 2;
            st  = 2'b00;
        end else begin
            lat = 4 + DEPTH;
            st  = 2'b10;
            for (int k = 0; k < tbl.size(); k++) begin
                if (tbl_syn[k] == s) begin
                    lat = 4 + k;
                    err = tbl[k];
                    st  = 2'b01;
                    break;
                end
            end
        end
        fixed = w ^ err;
        msg   = fixed[15:11];
    endtask

    task automatic run_word(input logic [15:0] w, input int hold);
        int          lat_exp;
        int          lat;
        logic [4:0]  m_exp;
        logic [15:0] e_exp;
        logic [1:0]  s_exp;
        ref_decode(w, lat_exp, m_exp, e_exp, s_exp);
        if (s_exp == 2'b01 && exp_corr < 65535) exp_corr++;
        if (s_exp == 2'b10 && exp_uncorr < 65535) exp_uncorr++;

        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_word  = w;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (!out_valid && lat < 1000) begin
            in_valid = 1'($urandom);
            in_word  = 16'($urandom);
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            check_eq("timeout", 32'(lat), 32'(lat_exp));
            finish_test();
        end
        check_eq("latency", 32'(lat), 32'(lat_exp));
        check_eq("msg", 32'(out_msg), 32'(m_exp));
        check_eq("err", 32'(out_err), 32'(e_exp));
        check_eq("status", 32'(out_status), 32'(s_exp));
        check_eq("corr_cnt", 32'(corr_cnt), 32'(exp_corr));
        check_eq("uncorr_cnt", 32'(uncorr_cnt), 32'(exp_uncorr));
        check_eq("in_ready_busy", 32'(in_ready), 32'd0);

        for (int h = 0; h < hold; h++) begin
            in_valid  = 1'b1;
            in_word   = ~w;
            out_ready = 1'b0;
            @(negedge clk);
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_in_ready", 32'(in_ready), 32'd0);
            check_eq("hold_msg", 32'(out_msg), 32'(m_exp));
            check_eq("hold_err", 32'(out_err), 32'(e_exp));
            check_eq("hold_status", 32'(out_status), 32'(s_exp));
            check_eq("hold_corr", 32'(corr_cnt), 32'(exp_corr));
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("post_valid", 32'(out_valid), 32'd0);
        check_eq("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_msg"}, 32'(out_msg), 32'd0);
        check_eq({tag, "_err"}, 32'(out_err), 32'd0);
        check_eq({tag, "_status"}, 32'(out_status), 32'd0);
        check_eq({tag, "_corr"}, 32'(corr_cnt), 32'd0);
        check_eq({tag, "_uncorr"}, 32'(uncorr_cnt), 32'd0);
    endtask

    initial begin
        #900000;
        n_fail++;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        finish_test();
    end

    initial begin
        logic [15:0] e;
        int          we;

        for (int w = 1; w <= 3; w++) begin
            for (int v = 65535; v > 0; v--) begin
                if ($countones(v[15:0]) == w) begin
                    tbl.push_back(v[15:0]);
                    tbl_syn.push_back(ref_syn(v[15:0]));
                end
            end
        end

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_in_ready", 32'(in_ready), 32'd1);

        run_word(16'h0000, 1);
        run_word(16'h8000, 5);
        run_word(16'hF000, 0);

        // Reset in the middle of a table scan
        in_valid = 1'b1;
        in_word  = 16'hF000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (99) @(negedge clk);
        check_eq("scan_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        exp_corr   = 0;
        exp_uncorr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        run_word(16'h0000, 0);

        for (int t = 0; t < 30; t++) begin
            e  = 16'h0000;
            we = int'($urandom_range(0, 4));
            while ($countones(e) < we) e = e | (16'h0001 << $urandom_range(0, 15));
            run_word(encode(5'($urandom)) ^ e, int'($urandom_range(0, 3)));
        end

        finish_test();
    end

endmodule
`default_nettype wire

// File: doc/rm14_decode_ctrl.md
RM14_DECODE_CTRL -- requirements
Module: rm14_decode_ctrl

Interface
REQ-001 SHALL have parameter TABLE_DEPTH, default 697, number of coset-leader entries (all error patterns of weight 1..3, weight-ascending).
REQ-002 SHALL have parameter ADDR_W, default 10, width of the table address counter.
REQ-003 SHALL have port clk, input, 1, the single clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, received word offered.
REQ-006 SHALL have port in_ready, output, 1, controller accepts a word.
REQ-007 SHALL have port in_word, input, 16, received word; bit 15 = r0 ... bit 0 = r15.
REQ-008 SHALL have port out_valid, output, 1, result available.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port out_msg, output, 5, decoded message, r0..r4 of the corrected word.
REQ-011 SHALL have port out_err, output, 16, applied error pattern.
REQ-012 SHALL have port out_status, output, 2, with 00 = clean, 01 = corrected, 10 = uncorrectable.
REQ-013 SHALL have ports corr_cnt and uncorr_cnt, output, 16 each, saturating event counters.

Function
REQ-014 SHALL implement FSM states IDLE, SYND, SEARCH, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE. in_valid in any other state SHALL be ignored.
REQ-016 IDLE: on in_valid&in_ready, SHALL register in_word and go to SYND.
REQ-017 SYND (1 cycle): SHALL register the 11-bit syndrome s = word·Hᵀ, with s0=r0^r1^r2^r5, s1=r0^r1^r3^r6, s2=r0^r1^r4^r7, s3=r0^r2^r3^r8, s4=r0^r2^r4^r9, s5=r0^r3^r4^r10, s6=r1^r2^r3^r11, s7=r1^r2^r4^r12, s8=r1^r3^r4^r13, s9=r2^r3^r4^r14, s10=r0^r1^r2^r3^r4^r15.
REQ-018 If s==0, SHALL go to DONE with status 00, out_err 0, out_msg = word[15:11]; out_valid rises 2 cycles after the accept edge.
REQ-019 If s!=0, SHALL go to SEARCH and clear the address counter to 0.
REQ-020 SEARCH: SHALL issue one ROM address per cycle. ROM data for address k SHALL be compared one cycle later.
REQ-021 On the first syndrome match at entry k, SHALL go to DONE with status 01 and out_err = ROM pattern. Matching SHALL be first-match-wins; later entries are not examined.
REQ-022 Match latency: out_valid SHALL rise at 4+k cycles after the accept edge.
REQ-023 Exhaustion (entry TABLE_DEPTH-1 compared with no match): SHALL go to DONE with status 10, out_err 0, out_msg = raw word[15:11]. The address counter SHALL NOT wrap.
REQ-024 out_msg SHALL equal (word ^ out_err)[15:11].
REQ-025 DONE: out_valid=1, and all out_* SHALL be held stable until out_valid&out_ready. On that handshake, SHALL return to IDLE; the next word is acceptable the following cycle.
REQ-026 On entering DONE, corr_cnt SHALL increment if status is 01, and uncorr_cnt SHALL increment if status is 10. Both SHALL saturate at 0xFFFF.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, in_ready=1 after release, out_valid=0, out_msg=0, out_err=0, out_status=00, counters 0, and address counter 0.
REQ-028 Reset asserted mid-SEARCH or in DONE SHALL discard the word with no output handshake.

Structure
REQ-029 Package rm14_pkg SHALL hold the H-matrix column masks, TABLE_DEPTH, the status encoding, and the FSM state enum.
REQ-030 Sub-module rm14_syndrome_rom SHALL hold the table: ADDR_W address in, 11-bit syndrome plus 16-bit pattern out, synchronous 1-cycle read.

Verification
REQ-031 in_word=0x0000 -> out_valid at cycle +2, msg=00000, err=0x0000, status=00, counters unchanged.
REQ-032 in_word=0x8000 (r0 flipped, entry 0) -> out_valid at cycle +4, err=0x8000, msg=00000, status=01, corr_cnt=1.
REQ-033 in_word=0xF000 (weight-4 error) -> out_valid at cycle +701, status=10, msg=11110, uncorr_cnt=1.
REQ-034 After REQ-032, hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, a new in_valid is not accepted.
REQ-035 Assert rst_n=0 at cycle +100 of the REQ-033 search -> immediate IDLE, out_valid=0, counters 0; next 0x0000 decodes per REQ-031.
